// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_arbiter
//  Brief    : Round-robin arbiter sharing one APB master port among NUM_REQ
//             requesters, with slave decode and pready timeout.
//  Revision : 1.0
// ============================================================================
module apb_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SLV_IDX_LSB    = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            pclk,
  input  logic                            preset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_err,
  output logic [NUM_SLAVES-1:0]           psel,
  output logic                            penable,
  output logic                            pwrite,
  output logic [ADDR_WIDTH-1:0]           paddr,
  output logic [DATA_WIDTH-1:0]           pwdata,
  input  logic [DATA_WIDTH-1:0]           prdata,
  input  logic                            pready,
  input  logic                            pslverr
);

  localparam int c_PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_SUM_W  = c_PTR_W + 1;
  localparam int c_SIDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int c_CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DECERR = 2'd3
  } state_t;

  state_t                 r_state;
  logic [c_PTR_W-1:0]     r_ptr;
  logic [c_PTR_W-1:0]     r_owner;
  logic [c_CNT_W-1:0]     r_cnt;

  logic [NUM_REQ-1:0]     w_rot;
  logic                   w_found;
  logic [c_SUM_W-1:0]     w_sum;
  logic [c_PTR_W-1:0]     w_gnt;
  logic                   w_grant;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [DATA_WIDTH-1:0]  w_wdata;
  logic                   w_write;
  logic [ADDR_WIDTH-1:0]  w_idx_full;
  logic                   w_dec_ok;
  logic [NUM_SLAVES-1:0]  w_psel_oh;
  logic                   w_timeout;

  // Rotate so bit 0 is the requester at the round-robin pointer.
  always_comb begin
    w_rot   = NUM_REQ'({req_valid, req_valid} >> r_ptr);
    w_found = 1'b0;
    w_sum   = '0;
    w_gnt   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + c_SUM_W'(k);
        if (w_sum >= c_SUM_W'(NUM_REQ)) begin
          w_sum = w_sum - c_SUM_W'(NUM_REQ);
        end
        w_gnt = w_sum[c_PTR_W-1:0];
      end
    end
  end

  assign w_addr  = req_addr[w_gnt*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_wdata = req_wdata[w_gnt*DATA_WIDTH +: DATA_WIDTH];
  assign w_write = req_write[w_gnt];

  // All address bits above the index LSB take part, so any address beyond
  // the last slave window is a decode error rather than an alias.
  assign w_idx_full = w_addr >> SLV_IDX_LSB;
  assign w_dec_ok   = (w_idx_full < ADDR_WIDTH'(NUM_SLAVES));
  assign w_psel_oh  = w_dec_ok ? (NUM_SLAVES'(1) << w_addr[SLV_IDX_LSB +: c_SIDX_W])
                               : '0;

  // The IDLE cycle carrying a response never grants, giving a gap cycle.
  assign w_grant   = (r_state == S_IDLE) && (rsp_valid == '0) && w_found && !preset;
  assign req_ready = w_grant ? (NUM_REQ'(1) << w_gnt) : '0;

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == c_CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            paddr   <= w_addr;
            pwrite  <= w_write;
            pwdata  <= w_wdata;
            r_owner <= w_gnt;
            r_ptr   <= (w_gnt == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt + c_PTR_W'(1);
            if (w_dec_ok) begin
              psel    <= w_psel_oh;
              r_state <= S_SETUP;
            end else begin
              r_state <= S_DECERR;
            end
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
          r_cnt   <= c_CNT_W'(1);
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            psel      <= '0;
            penable   <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << r_owner;
            rsp_rdata <= (pwrite || pslverr) ? '0 : prdata;
            rsp_err   <= pslverr;
            r_state   <= S_IDLE;
          end else if (w_timeout) begin
            psel      <= '0;
            penable   <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << r_owner;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_DECERR: begin
          rsp_valid <= NUM_REQ'(1) << r_owner;
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master_arbiter
//  Brief    : Directed self-checking bench for apb_master_arbiter.
//  Revision : 1.0
// ============================================================================
module tb_apb_master_arbiter;
  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;

  logic              pclk;
  logic              preset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [NS-1:0]     psel;
  logic              penable;
  logic              pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [DW-1:0]     prdata;
  logic              pready;
  logic              pslverr;

  int n_vec = 0;
  int n_err = 0;

  apb_master_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .NUM_SLAVES(NS), .SLV_IDX_LSB(12), .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_write[i]           = w;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  initial begin
    int g;
    int n;
    preset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick(); tick();
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    preset = 1'b0;
    tick();

    // T1 single read
    set_req(0, 1'b0, 32'h0000_1004, 32'h0);
    prdata = 32'hCAFE_F00D; pready = 1'b1; req_valid = 2'b01;
    #1;
    chk("t1_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    chk("t1_setup_psel", psel, 4'b0010);
    chk("t1_setup_penable", penable, 0);
    chk("t1_paddr", paddr, 32'h0000_1004);
    chk("t1_ready_drop", req_ready, 0);
    tick();
    chk("t1_access_psel", psel, 4'b0010);
    chk("t1_access_penable", penable, 1);
    tick();
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_idle_psel", psel, 0);
    chk("t1_idle_penable", penable, 0);
    tick();

    // T2 contention from reset
    preset = 1'b1;
    tick();
    preset = 1'b0;
    set_req(0, 1'b0, 32'h0000_0010, 32'h0);
    set_req(1, 1'b1, 32'h0000_2020, 32'h1234_5678);
    prdata = 32'hA5A5_0001; req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      g = i % 2;
      chk("t2_ready", req_ready, (g == 1) ? 2'b10 : 2'b01);
      tick();
      chk("t2_psel", psel, (g == 1) ? 4'b0100 : 4'b0001);
      chk("t2_pwrite", pwrite, g);
      chk("t2_pwdata", pwdata, (g == 1) ? 32'h1234_5678 : 32'h0);
      tick();
      chk("t2_penable", penable, 1);
      tick();
      chk("t2_rsp_valid", rsp_valid, (g == 1) ? 2'b10 : 2'b01);
      chk("t2_rsp_rdata", rsp_rdata, (g == 1) ? 32'h0 : 32'hA5A5_0001);
      chk("t2_gap_ready", req_ready, 0);
      tick();
    end
    req_valid = 2'b00;
    #1;
    chk("t2_withdraw_ready", req_ready, 0);
    tick(); tick();
    chk("t2_withdraw_psel", psel, 0);

    // T3 wait states then slave error
    set_req(0, 1'b0, 32'h0000_3008, 32'h0);
    prdata = 32'h0; pready = 1'b0; pslverr = 1'b0; req_valid = 2'b01;
    #1;
    chk("t3_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    chk("t3_setup_psel", psel, 4'b1000);
    chk("t3_setup_penable", penable, 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t3_penable", penable, 1);
      chk("t3_paddr", paddr, 32'h0000_3008);
      chk("t3_psel", psel, 4'b1000);
      if (k == 6) begin
        pready = 1'b1; pslverr = 1'b1;
      end
    end
    tick();
    chk("t3_rsp_valid", rsp_valid, 2'b01);
    chk("t3_rsp_err", rsp_err, 1);
    chk("t3_rsp_rdata", rsp_rdata, 0);
    chk("t3_penable_low", penable, 0);
    pready = 1'b0; pslverr = 1'b0;
    tick();

    // T4 timeout
    set_req(1, 1'b0, 32'h0000_0100, 32'h0);
    prdata = 32'h5555_5555; req_valid = 2'b10;
    #1;
    chk("t4_ready", req_ready, 2'b10);
    tick(); req_valid = 2'b00;
    chk("t4_setup_psel", psel, 4'b0001);
    tick();
    n = 0;
    while (penable === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("t4_access_cycles", n, 16);
    chk("t4_rsp_valid", rsp_valid, 2'b10);
    chk("t4_rsp_err", rsp_err, 1);
    chk("t4_rsp_rdata", rsp_rdata, 0);
    tick();

    // T5 decode error
    set_req(0, 1'b0, 32'h0000_5000, 32'h0);
    prdata = 32'h7777_7777; pready = 1'b1; req_valid = 2'b01;
    #1;
    chk("t5_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    chk("t5_psel", psel, 0);
    chk("t5_penable", penable, 0);
    chk("t5_no_early_rsp", rsp_valid, 0);
    tick();
    chk("t5_rsp_valid", rsp_valid, 2'b01);
    chk("t5_rsp_err", rsp_err, 1);
    chk("t5_rsp_rdata", rsp_rdata, 0);
    chk("t5_psel_idle", psel, 0);
    tick();

    // T6 reset during ACCESS
    set_req(0, 1'b0, 32'h0000_2000, 32'h0);
    pready = 1'b0; req_valid = 2'b01;
    #1;
    chk("t6_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    tick();
    chk("t6_access_penable", penable, 1);
    chk("t6_access_psel", psel, 4'b0100);
    preset = 1'b1; req_valid = 2'b11;
    #1;
    chk("t6_ready_in_reset", req_ready, 0);
    tick();
    chk("t6_rst_psel", psel, 0);
    chk("t6_rst_penable", penable, 0);
    chk("t6_rst_paddr", paddr, 0);
    chk("t6_rst_rsp_valid", rsp_valid, 0);
    chk("t6_rst_rsp_err", rsp_err, 0);
    pready = 1'b1;
    tick();
    chk("t6_rst_no_rsp", rsp_valid, 0);
    preset = 1'b0;
    #1;
    chk("t6_first_grant", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    chk("t6_post_psel", psel, 4'b0100);
    tick(); tick();
    chk("t6_post_rsp", rsp_valid, 2'b01);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
